// File: rtl/gcd_host_sequencer_if.sv
// Operand, core-load and result channels between the GCD host sequencer and its environment.
// master = sequencer side, slave = upstream/core/downstream side.
interface gcd_host_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             done;
    logic [WIDTH-1:0] core_gcd;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_gcd;
    logic             res_err;
    logic             busy;

    modport master (
        input  op_valid, op_a, op_b, done, core_gcd, res_ready,
        output op_ready, start, data_in, res_valid, res_gcd, res_err, busy
    );

    modport slave (
        output op_valid, op_a, op_b, done, core_gcd, res_ready,
        input  op_ready, start, data_in, res_valid, res_gcd, res_err, busy
    );
endinterface

// File: rtl/gcd_host_sequencer.sv
// Host-side initiator for the serial-load GCD core: loads A then B, waits for done
// (with timeout), bypasses zero operands and presents the result on a valid/ready channel.
module gcd_host_sequencer #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gcd_host_sequencer_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic             r_start,     w_start_nxt;
    logic [WIDTH-1:0] r_data_in,   w_data_in_nxt;
    logic             r_res_valid, w_res_valid_nxt;
    logic [WIDTH-1:0] r_res_gcd,   w_res_gcd_nxt;
    logic             r_res_err,   w_res_err_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [WIDTH-1:0] r_op_b,      w_op_b_nxt;
    logic             w_zero_op;

    // A goes straight into the data_in register; only B needs its own holding register.
    assign w_zero_op = (bus.op_a == '0) || (bus.op_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_start     <= 1'b0;
            r_data_in   <= '0;
            r_res_valid <= 1'b0;
            r_res_gcd   <= '0;
            r_res_err   <= 1'b0;
            r_cnt       <= '0;
            r_op_b      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_start     <= w_start_nxt;
            r_data_in   <= w_data_in_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_gcd   <= w_res_gcd_nxt;
            r_res_err   <= w_res_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op_b      <= w_op_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_start_nxt     = 1'b0;
        w_data_in_nxt   = r_data_in;
        w_res_valid_nxt = r_res_valid;
        w_res_gcd_nxt   = r_res_gcd;
        w_res_err_nxt   = r_res_err;
        w_cnt_nxt       = r_cnt;
        w_op_b_nxt      = r_op_b;

        case (r_state)
            S_IDLE: begin
                if (bus.op_valid) begin
                    w_op_b_nxt = bus.op_b;
                    if (w_zero_op) begin
                        // gcd(0,x)=x and gcd(0,0)=0 without involving the core
                        w_state_nxt     = S_HOLD;
                        w_res_valid_nxt = 1'b1;
                        w_res_gcd_nxt   = bus.op_a | bus.op_b;
                        w_res_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt   = S_LOAD_A;
                        w_start_nxt   = 1'b1;
                        w_data_in_nxt = bus.op_a;
                    end
                end
            end
            S_LOAD_A: begin
                w_state_nxt   = S_LOAD_B;
                w_data_in_nxt = r_op_b;
            end
            S_LOAD_B: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                if (bus.done) begin
                    w_state_nxt     = S_HOLD;
                    w_res_valid_nxt = 1'b1;
                    w_res_gcd_nxt   = bus.core_gcd;
                    w_res_err_nxt   = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = S_HOLD;
                    w_res_valid_nxt = 1'b1;
                    w_res_gcd_nxt   = '0;
                    w_res_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_res_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.op_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.start     = r_start;
    assign bus.data_in   = r_data_in;
    assign bus.res_valid = r_res_valid;
    assign bus.res_gcd   = r_res_gcd;
    assign bus.res_err   = r_res_err;
endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Directed bench for gcd_host_sequencer with a behavioural serial-load GCD core model.
module tb_gcd_host_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gcd_host_sequencer_if #(.WIDTH(16)) bus ();

    gcd_host_sequencer #(.WIDTH(16), .TIMEOUT_CYCLES(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Core model: samples A while start=1, B the next edge, then Euclid one step per cycle.
    logic        hang  = 1'b0;
    logic [1:0]  m_ph  = 2'd0;
    logic [15:0] m_a   = '0;
    logic [15:0] m_b   = '0;
    logic        m_done = 1'b0;
    logic [15:0] m_gcd = '0;
    assign bus.done     = m_done;
    assign bus.core_gcd = m_gcd;

    always @(posedge clk) begin
        if (bus.start) begin
            m_a    <= bus.data_in;
            m_ph   <= 2'd1;
            m_done <= 1'b0;
        end else if (m_ph == 2'd1) begin
            m_b  <= bus.data_in;
            m_ph <= 2'd2;
        end else if (m_ph == 2'd2 && !hang) begin
            if (m_b == 16'd0) begin
                m_done <= 1'b1;
                m_gcd  <= m_a;
                m_ph   <= 2'd0;
            end else begin
                m_a <= m_b;
                m_b <= m_a % m_b;
            end
        end
    end

    int start_cnt = 0;
    always @(posedge clk) if (bus.start) start_cnt <= start_cnt + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_res(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("res_valid_seen", 32'(got), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_g, input logic byp);
        int s0;
        @(negedge clk);
        check("op_ready_idle", 32'(bus.op_ready), 32'd1);
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        s0           = start_cnt;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_a     = ~a;
        bus.op_b     = ~b;
        if (byp) begin
            check("byp_valid", 32'(bus.res_valid), 32'd1);
            check("byp_start", 32'(bus.start), 32'd0);
        end else begin
            check("load_a_start", 32'(bus.start), 32'd1);
            check("load_a_data", 32'(bus.data_in), 32'(a));
            @(negedge clk);
            check("load_b_start", 32'(bus.start), 32'd0);
            check("load_b_data", 32'(bus.data_in), 32'(b));
            wait_res(60);
        end
        check("res_gcd", 32'(bus.res_gcd), 32'(exp_g));
        check("res_err", 32'(bus.res_err), 32'd0);
        check("start_pulses", 32'(start_cnt - s0), byp ? 32'd0 : 32'd1);
        @(negedge clk);
        check("res_valid_clr", 32'(bus.res_valid), 32'd0);
        check("op_ready_back", 32'(bus.op_ready), 32'd1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic        byp;
    } vec_t;
    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, k, nres, res1_k, st2_k, seen;
        logic [15:0] res_q[2];

        vecs[0] = '{16'd143,   16'd78,    16'd13,  1'b0};
        vecs[1] = '{16'd0,     16'd48,    16'd48,  1'b1};
        vecs[2] = '{16'd0,     16'd0,     16'd0,   1'b1};
        vecs[3] = '{16'd48,    16'd0,     16'd48,  1'b1};
        vecs[4] = '{16'd17,    16'd5,     16'd1,   1'b0};
        vecs[5] = '{16'd64,    16'd48,    16'd16,  1'b0};
        vecs[6] = '{16'd105,   16'd84,    16'd21,  1'b0};
        vecs[7] = '{16'd1,     16'd1,     16'd1,   1'b0};
        vecs[8] = '{16'd65535, 16'd255,   16'd255, 1'b0};
        vecs[9] = '{16'd1,     16'd65535, 16'd1,   1'b0};

        rst_n         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_op_ready", 32'(bus.op_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_start", 32'(bus.start), 32'd0);
        check("rst_data_in", 32'(bus.data_in), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_gcd", 32'(bus.res_gcd), 32'd0);
        check("rst_res_err", 32'(bus.res_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].byp);

        // Downstream stall: result must hold and new operands must be refused.
        bus.res_ready = 1'b0;
        @(negedge clk);
        s0           = start_cnt;
        bus.op_valid = 1'b1;
        bus.op_a     = 16'd105;
        bus.op_b     = 16'd84;
        @(negedge clk);
        bus.op_valid = 1'b0;
        wait_res(60);
        for (int i = 0; i < 5; i++) begin
            check("hold_gcd", 32'(bus.res_gcd), 32'd21);
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_op_ready", 32'(bus.op_ready), 32'd0);
            bus.op_valid = 1'b1;
            bus.op_a     = 16'd7;
            bus.op_b     = 16'd3;
            @(negedge clk);
        end
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", 32'(bus.res_valid), 32'd0);
        check("hold_release_ready", 32'(bus.op_ready), 32'd1);
        check("hold_no_extra_start", 32'(start_cnt - s0), 32'd1);

        // Hung core: result flagged 20 cycles after entering WAIT (WAIT entered at k=2).
        hang = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_a     = 16'd50;
        bus.op_b     = 16'd30;
        @(negedge clk);
        bus.op_valid = 1'b0;
        check("to_start", 32'(bus.start), 32'd1);
        repeat (21) @(negedge clk);
        check("to_not_yet", 32'(bus.res_valid), 32'd0);
        check("to_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("to_valid", 32'(bus.res_valid), 32'd1);
        check("to_err", 32'(bus.res_err), 32'd1);
        check("to_gcd", 32'(bus.res_gcd), 32'd0);
        @(negedge clk);
        check("to_clr", 32'(bus.res_valid), 32'd0);

        // Reset while waiting on the core.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_a     = 16'd143;
        bus.op_b     = 16'd78;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", 32'(bus.start), 32'd0);
        check("mid_rst_data_in", 32'(bus.data_in), 32'd0);
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_err", 32'(bus.res_err), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_op_ready", 32'(bus.op_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        hang  = 1'b0;
        seen  = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);
        run_op(16'd36, 16'd24, 16'd12, 1'b0);

        // Back-to-back pairs with op_valid held high.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_a     = 16'd17;
        bus.op_b     = 16'd5;
        k = 0; nres = 0; res1_k = -1; st2_k = -1;
        res_q[0] = '0;
        res_q[1] = '0;
        for (int i = 0; i < 200 && nres < 2; i++) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("b2b_start1", 32'(bus.start), 32'd1);
                check("b2b_data_a1", 32'(bus.data_in), 32'd17);
                bus.op_a = 16'd64;
                bus.op_b = 16'd48;
            end
            if (k == 2) check("b2b_data_b1", 32'(bus.data_in), 32'd5);
            if (bus.start && k > 1) begin
                st2_k = k;
                check("b2b_data_a2", 32'(bus.data_in), 32'd64);
                bus.op_valid = 1'b0;
            end
            if (bus.res_valid) begin
                res_q[nres] = bus.res_gcd;
                if (nres == 0) res1_k = k;
                nres++;
            end
        end
        check("b2b_nres", 32'(nres), 32'd2);
        check("b2b_res1", 32'(res_q[0]), 32'd1);
        check("b2b_res2", 32'(res_q[1]), 32'd16);
        check("b2b_order", 32'(st2_k), 32'(res1_k + 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_host_sequencer.md
Name: gcd_host_sequencer

Overview:
- Host-side initiator for the serial-load GCD core (datapath plus controller).
- Accepts an operand pair on a valid/ready handshake and drives the core's start/data_in loading sequence: A first, then B.
- Waits for the core's done, captures the core's result and presents it downstream on a second valid/ready handshake.
- Shields the core from inputs it cannot terminate on: zero operands are bypassed, and a hung core is caught by a timeout.

Parameters:
- WIDTH, 16, operand/result width; matches core data_in.
- TIMEOUT_CYCLES, 1023, maximum cycles spent in WAIT before aborting with an error.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  upstream operand pair valid.
- op_ready  out  1  sequencer can accept a pair.
- op_a  in  WIDTH  first operand.
- op_b  in  WIDTH  second operand.
- start  out  1  start request to GCD core.
- data_in  out  WIDTH  serial operand bus to GCD core.
- done  in  1  core completion flag.
- core_gcd  in  WIDTH  core result (core A register); valid while done=1.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_gcd  out  WIDTH  GCD result.
- res_err  out  1  result aborted by timeout; res_gcd=0 when set.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous, any state, takes effect immediately:
  - state=IDLE.
  - start=0, data_in=0, res_valid=0, res_gcd=0, res_err=0, busy=0, op_ready=1.
  - timeout counter=0, operand registers=0.
- State machine (encoded; all outputs registered except op_ready and busy, which decode state):
  - IDLE: op_ready=1. On op_valid&op_ready, latch op_a/op_b.
    - If op_a==0 or op_b==0: go to HOLD with res_gcd=op_a|op_b, res_err=0. Covers gcd(0,x)=x and gcd(0,0)=0; the core is not started.
    - Else go to LOAD_A.
  - LOAD_A: exactly one cycle; start=1, data_in=A. Next state LOAD_B.
  - LOAD_B: exactly one cycle; start=0, data_in=B. Next state WAIT; counter cleared.
  - WAIT: data_in holds B; counter increments each cycle.
    - done=1 sampled: capture core_gcd into res_gcd, res_err=0, go to HOLD.
    - Else if counter reaches TIMEOUT_CYCLES-1: res_gcd=0, res_err=1, go to HOLD.
    - If done and timeout coincide, done wins.
  - HOLD: res_valid=1; res_gcd and res_err stable. On res_ready go to IDLE, clearing res_valid the same edge. op_ready=0 throughout, so there is no overlap of operations.
- done is ignored outside WAIT. A stale done left high from the previous op is not sampled in LOAD_A/LOAD_B.
- Latency, core path: pair accepted at edge N, start high for cycle N..N+1, B driven cycle N+1..N+2, WAIT from edge N+2, res_valid high the edge after done is first sampled.
- Latency, bypass path: res_valid high one edge after acceptance.
- op_a/op_b changes after acceptance have no effect.
- Reset asserted mid-operation aborts it. No result is produced and the core sees start=0.

Test Plan:
- Reset, then op_a=143, op_b=78, res_ready=1 -> start pulses 1 cycle with data_in=143, next cycle data_in=78; after done: res_valid=1, res_gcd=13, res_err=0, then IDLE with op_ready=1.
- op_a=0, op_b=48 -> res_gcd=48 one cycle after acceptance, start never asserted. Repeat with 0/0 -> res_gcd=0, res_err=0.
- Core model never raises done, TIMEOUT_CYCLES=20 -> res_valid exactly 20 cycles after WAIT entry, res_err=1, res_gcd=0.
- res_ready held low 5 cycles in HOLD with result 21 (op 105, 84) -> res_gcd=21 stable, op_ready=0 and op_valid ignored; res_ready=1 -> IDLE next edge.
- rst_n pulsed low during WAIT of op 143/78 -> all outputs zero immediately, op_ready=1 and no res_valid for that op. A following op 36/24 -> res_gcd=12.
- Back-to-back pairs (17,5), (64,48) with op_valid held high and res_ready=1 -> results 1 then 16 in order; second pair accepted only after first res handshake.
